// File: rtl/conv1x1_pkg.sv
// Shared types and defaults for the 1x1 convolution sequencer.
package conv1x1_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDW  = 3'd1,
    RUN  = 3'd2,
    TAIL = 3'd3,
    OUT  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam int NPE_DEF     = 4;
  localparam int DWIDTH_DEF  = 16;
  localparam int MAX_CIN_DEF = 64;
  localparam int MAX_PIX_DEF = 4096;

  // ReLU gate for one lane: a negative sum (sign bit set) is masked to zero.
  function automatic logic relu_keep(input logic sign_bit);
    relu_keep = ~sign_bit;
  endfunction

endpackage

// File: rtl/conv1x1_wbuf.sv
// Weight register file: one write port, one asynchronous read port.
// Contents deliberately survive reset so a loaded weight set is never scrubbed.
module conv1x1_wbuf import conv1x1_pkg::*; #(
  parameter int NPE     = NPE_DEF,
  parameter int MAX_CIN = MAX_CIN_DEF,
  localparam int ABITS  = $clog2(MAX_CIN)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [NPE*8-1:0] wdata,
  input  logic [ABITS-1:0] raddr,
  output logic [NPE*8-1:0] rdata
);

  logic [NPE*8-1:0] mem_r [MAX_CIN];

  // Weight beat write during load
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/conv1x1_sched.sv
// Sequencer for a row of 1x1 PEs: loads weights, streams pixels, accumulates products.
// Optional macro CONV1X1_RELU_EN clamps negative output lanes to zero.
module conv1x1_sched import conv1x1_pkg::*; #(
  parameter int NPE     = NPE_DEF,
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int MAX_CIN = MAX_CIN_DEF,
  parameter int MAX_PIX = MAX_PIX_DEF,
  parameter int AWIDTH  = DWIDTH + $clog2(MAX_CIN),
  localparam int CW     = $clog2(MAX_CIN + 1),
  localparam int PW     = $clog2(MAX_PIX + 1),
  localparam int ABITS  = $clog2(MAX_CIN)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [CW-1:0]         cfg_cin,
  input  logic [PW-1:0]         cfg_npix,
  output logic                  busy,
  output logic                  done,
  input  logic                  wgt_valid,
  output logic                  wgt_ready,
  input  logic [NPE*8-1:0]      wgt_data,
  input  logic                  ifm_valid,
  output logic                  ifm_ready,
  input  logic [7:0]            ifm_data,
  output logic [7:0]            pe_ifm,
  output logic [NPE*8-1:0]      pe_wgt,
  input  logic [NPE*DWIDTH-1:0] pe_psum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NPE*AWIDTH-1:0] out_data
);

  state_t                state_r, next_s;
  logic [CW-1:0]         cin_r, ci_r;
  logic [PW-1:0]         npix_r, pix_r;
  logic                  issue_d_r, first_d_r;
  logic [NPE*AWIDTH-1:0] acc_r, psum_ext_s;
  logic                  wgt_fire_s, ifm_fire_s, out_fire_s, last_ci_s, last_pix_s;

  // Handshake readies decode straight from the state register
  assign busy      = (state_r != IDLE);
  assign done      = (state_r == DONE);
  assign wgt_ready = (state_r == LDW);
  assign ifm_ready = (state_r == RUN);
  assign out_valid = (state_r == OUT);

  assign wgt_fire_s = wgt_valid & wgt_ready;
  assign ifm_fire_s = ifm_valid & ifm_ready;
  assign out_fire_s = out_valid & out_ready;
  assign last_ci_s  = (ci_r == cin_r - CW'(1));
  assign last_pix_s = (pix_r + PW'(1) == npix_r);

  assign pe_ifm = ifm_data;

  conv1x1_wbuf #(.NPE(NPE), .MAX_CIN(MAX_CIN)) u_wbuf (
    .clk   (clk),
    .we    (wgt_fire_s),
    .waddr (ci_r[ABITS-1:0]),
    .wdata (wgt_data),
    .raddr (ci_r[ABITS-1:0]),
    .rdata (pe_wgt)
  );

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (cfg_cin == {CW{1'b0}} || cfg_npix == {PW{1'b0}}) next_s = DONE;
          else next_s = LDW;
        end else begin
          next_s = IDLE;
        end
      end
      LDW: begin
        if (wgt_fire_s && last_ci_s) next_s = RUN;
        else next_s = LDW;
      end
      RUN: begin
        if (ifm_fire_s && last_ci_s) next_s = TAIL;
        else next_s = RUN;
      end
      TAIL: next_s = OUT;
      OUT: begin
        if (out_fire_s) begin
          if (last_pix_s) next_s = DONE;
          else next_s = RUN;
        end else begin
          next_s = OUT;
        end
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State, job configuration, channel/pixel counters and issue alignment
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= IDLE;
      cin_r     <= {CW{1'b0}};
      npix_r    <= {PW{1'b0}};
      ci_r      <= {CW{1'b0}};
      pix_r     <= {PW{1'b0}};
      issue_d_r <= 1'b0;
      first_d_r <= 1'b0;
    end else begin
      state_r   <= next_s;
      issue_d_r <= ifm_fire_s;
      first_d_r <= ifm_fire_s && (ci_r == {CW{1'b0}});
      case (state_r)
        IDLE: begin
          if (start) begin
            cin_r  <= cfg_cin;
            npix_r <= cfg_npix;
            ci_r   <= {CW{1'b0}};
            pix_r  <= {PW{1'b0}};
          end
        end
        LDW: begin
          if (wgt_fire_s) ci_r <= last_ci_s ? {CW{1'b0}} : ci_r + CW'(1);
        end
        RUN: begin
          if (ifm_fire_s) ci_r <= last_ci_s ? {CW{1'b0}} : ci_r + CW'(1);
        end
        OUT: begin
          if (out_fire_s) pix_r <= pix_r + PW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  for (genvar k = 0; k < NPE; k++) begin : g_lane
    assign psum_ext_s[k*AWIDTH +: AWIDTH] =
      {{(AWIDTH-DWIDTH){pe_psum[k*DWIDTH+DWIDTH-1]}}, pe_psum[k*DWIDTH +: DWIDTH]};
`ifdef CONV1X1_RELU_EN
    assign out_data[k*AWIDTH +: AWIDTH] =
      acc_r[k*AWIDTH +: AWIDTH] & {AWIDTH{relu_keep(acc_r[k*AWIDTH+AWIDTH-1])}};
`else
    assign out_data[k*AWIDTH +: AWIDTH] = acc_r[k*AWIDTH +: AWIDTH];
`endif
  end

  // Per-lane accumulation, restarted by the first channel of each pixel
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_r <= {(NPE*AWIDTH){1'b0}};
    end else if (issue_d_r) begin
      for (int k = 0; k < NPE; k++) begin
        acc_r[k*AWIDTH +: AWIDTH] <= first_d_r ? psum_ext_s[k*AWIDTH +: AWIDTH]
                                   : acc_r[k*AWIDTH +: AWIDTH] + psum_ext_s[k*AWIDTH +: AWIDTH];
      end
    end
  end

endmodule

// File: tb/tb_conv1x1_sched.sv
// Randomized self-checking bench for conv1x1_sched with a registered-product PE model.
module tb_conv1x1_sched;

  localparam int NPE = 4;
  localparam int DW  = 16;
  localparam int AW  = 22;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [6:0]    cfg_cin;
  logic [12:0]   cfg_npix;
  logic          busy, done;
  logic          wgt_valid, wgt_ready;
  logic [31:0]   wgt_data;
  logic          ifm_valid, ifm_ready;
  logic [7:0]    ifm_data;
  logic [7:0]    pe_ifm;
  logic [31:0]   pe_wgt;
  logic [63:0]   pe_psum;
  logic          out_valid, out_ready;
  logic [87:0]   out_data;

  int n_vec = 0;
  int n_err = 0;

  byte    wl [64][4];
  byte    xv [512];
  longint expv [64][4];

  conv1x1_sched dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_cin(cfg_cin), .cfg_npix(cfg_npix),
    .busy(busy), .done(done),
    .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .wgt_data(wgt_data),
    .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm_data(ifm_data),
    .pe_ifm(pe_ifm), .pe_wgt(pe_wgt), .pe_psum(pe_psum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // PE row model: registered signed int8 x int8 product per lane
  always_ff @(posedge clk) begin
    for (int k = 0; k < NPE; k++) begin
      pe_psum[k*DW +: DW] <= 16'(signed'(pe_ifm) * signed'(pe_wgt[k*8 +: 8]));
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint lane(input int k);
    logic signed [AW-1:0] v;
    v = out_data[k*AW +: AW];
    return longint'(v);
  endfunction

  function automatic logic [31:0] pack_w(input int c);
    logic [31:0] p;
    for (int k = 0; k < NPE; k++) p[k*8 +: 8] = wl[c][k];
    return p;
  endfunction

  task automatic rand_data(input int cin, input int npix);
    for (int c = 0; c < cin; c++)
      for (int k = 0; k < NPE; k++) wl[c][k] = byte'($urandom);
    for (int i = 0; i < cin * npix; i++) xv[i] = byte'($urandom);
  endtask

  // Runs one job; abort >= 0 pulls reset at that cycle instead of finishing.
  task automatic run_job(input int cin, input int npix, input int bubble,
                         input int stall, input int abort);
    int wi, xi, po, fire_cyc, hs_cyc, stall_left;
    bit fin;
    longint s;
    for (int p = 0; p < npix; p++)
      for (int k = 0; k < NPE; k++) begin
        s = 0;
        for (int c = 0; c < cin; c++) s += longint'(wl[c][k]) * longint'(xv[p*cin + c]);
`ifdef CONV1X1_RELU_EN
        if (s < 0) s = 0;
`endif
        expv[p][k] = s;
      end
    wi = 0; xi = 0; po = 0; fin = 1'b0; fire_cyc = -10; hs_cyc = -10; stall_left = stall;
    cfg_cin = 7'(cin); cfg_npix = 13'(npix); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc == abort) begin
        chk("abort_in_run", ifm_ready, 1);
        wgt_valid = 1'b0; ifm_valid = 1'b0; out_ready = 1'b0; rstn = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_ifm_ready", ifm_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_acc", lane(0), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        return;
      end
      if (done) begin
        if (cin == 0 || npix == 0) begin
          chk("done_lat_empty", cyc, 0);
          chk("no_wgt_beats", wi, 0);
          chk("no_ifm_beats", xi, 0);
        end else begin
          chk("done_after_hs", cyc, hs_cyc + 1);
          chk("pix_count", po, npix);
          chk("wgt_beats", wi, cin);
          chk("ifm_beats", xi, cin * npix);
        end
        fin = 1'b1;
        break;
      end
      if (out_valid) begin
        if (fire_cyc >= 0) begin
          chk("out_latency", cyc - fire_cyc, 2);
          fire_cyc = -10;
        end
        chk("ifm_ready_in_out", ifm_ready, 0);
        for (int k = 0; k < NPE; k++) chk("out_lane", lane(k), expv[po][k]);
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          po++;
          if (po == npix) hs_cyc = cyc;
        end
      end else begin
        out_ready = 1'($urandom_range(1));
      end
      wgt_valid = 1'b1;
      if (wi < cin) begin
        wgt_data = pack_w(wi);
      end else begin
        wgt_data = 32'hDEAD_BEEF;
        chk("wgt_ready_outside_ldw", wgt_ready, 0);
      end
      if (wgt_valid && wgt_ready) wi++;
      if (xi < cin * npix && $urandom_range(99) >= bubble) begin
        ifm_valid = 1'b1;
        ifm_data  = xv[xi];
      end else begin
        ifm_valid = 1'b0;
      end
      if (ifm_valid && ifm_ready) begin
        if (xi % cin == cin - 1) fire_cyc = cyc;
        xi++;
      end
      @(posedge clk); #1;
    end
    wgt_valid = 1'b0; ifm_valid = 1'b0; out_ready = 1'b0;
    if (!fin) begin
      chk("timeout", 0, 1);
    end else begin
      @(posedge clk); #1;
      chk("done_pulse", done, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    int cin, npix;
    rstn = 1'b0; start = 1'b0; cfg_cin = 7'd0; cfg_npix = 13'd0;
    wgt_valid = 1'b0; wgt_data = 32'd0; ifm_valid = 1'b0; ifm_data = 8'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_wgt_ready", wgt_ready, 0);
    chk("reset_ifm_ready", ifm_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    for (int k = 0; k < NPE; k++) chk("reset_out_data", lane(k), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // single channel, single pixel
    for (int k = 0; k < NPE; k++) wl[0][k] = byte'(k + 1);
    xv[0] = 8'sd5;
    run_job(1, 1, 0, 0, -1);

    // negative weights, two pixels
    for (int c = 0; c < 3; c++) for (int k = 0; k < NPE; k++) wl[c][k] = -8'sd1;
    for (int i = 0; i < 6; i++) xv[i] = byte'(i + 1);
    run_job(3, 2, 0, 0, -1);

    // full-depth extreme products
    for (int c = 0; c < 64; c++) begin
      for (int k = 0; k < NPE; k++) wl[c][k] = -8'sd128;
      xv[c] = -8'sd128;
    end
    run_job(64, 1, 0, 0, -1);

    // output backpressure
    rand_data(5, 3);
    run_job(5, 3, 0, 10, -1);

    // input bubbles
    rand_data(4, 4);
    run_job(4, 4, 50, 0, -1);

    // degenerate configurations
    run_job(0, 3, 0, 0, -1);
    run_job(2, 0, 0, 0, -1);

    // reset mid-RUN, then a clean job
    rand_data(4, 2);
    run_job(4, 2, 0, 0, 6);
    rand_data(3, 2);
    run_job(3, 2, 20, 2, -1);

    for (int j = 0; j < 6; j++) begin
      cin  = $urandom_range(8, 1);
      npix = $urandom_range(4, 1);
      rand_data(cin, npix);
      run_job(cin, npix, $urandom_range(60), $urandom_range(3), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
